// File: rtl/lpupf_pwr_ctrl_if.sv
// lpupf_pwr_ctrl_if: request handshake between a power-policy master and the power controller
interface lpupf_pwr_ctrl_if;
    logic       req_valid;
    logic       req_ready;
    logic [2:0] req_dom;
    logic       req_on;
    modport master (output req_valid, req_dom, req_on, input req_ready);
    modport slave (input req_valid, req_dom, req_on, output req_ready);
endinterface

// File: rtl/lpupf_pwr_ctrl.sv
// lpupf_pwr_ctrl: one-domain-at-a-time switch/isolation sequencer for five domains; LPUPF_TIMEOUT_EN adds a fail-safe power-ack timeout
module lpupf_pwr_ctrl #(
    parameter int ISO_DLY = 4,
    parameter int ACK_TO  = 16
) (
    input  logic            clk_upf,
    input  logic            rst_n_upf,
    lpupf_pwr_ctrl_if.slave req,
    input  logic [4:0]      pwr_ack,
    output logic            ctrl_a,
    output logic            ctrl_b,
    output logic            ctrl_c,
    output logic            ctrl_d,
    output logic            ctrl_e,
    output logic            Isola,
    output logic            Isolb,
    output logic            Isolc,
    output logic            Isold,
    output logic            Isole,
    output logic            ISO,
    output logic [4:0]      pwr_state,
    output logic            busy,
    output logic            done,
    output logic            err
);
    typedef enum logic [2:0] {IDLE, ISO_SET, ISO_WAIT, SW_OFF, SW_ON, ACK_WAIT, DEISO_WAIT, ISO_CLR} state_t;
    localparam logic [7:0] ISO_CNT = 8'(ISO_DLY);
    localparam logic [7:0] ACK_CNT = 8'(ACK_TO);
    state_t     state, state_n;
    logic [4:0] ctrl, ctrl_n, isol, isol_n, ps, ps_n, sel, req_sel;
    logic [7:0] cnt, cnt_n;
    logic [2:0] dom, dom_n;
    logic       on, on_n, done_n, err_n, live, idle, ack_hit;
    assign idle = state == IDLE;
    assign req.req_ready = live & idle;
    assign busy = live & ~idle;
    assign sel = 5'b1 << dom;
    assign req_sel = 5'b1 << req.req_dom;
    assign ack_hit = (|(pwr_ack & sel)) == on;
    assign {ctrl_e, ctrl_d, ctrl_c, ctrl_b, ctrl_a} = ctrl;
    assign {Isole, Isold, Isolc, Isolb, Isola} = isol;
    assign ISO = |isol;
    assign pwr_state = ps;
    // sequence decode: next state plus next value of every registered output
    always_comb begin
        state_n = state;
        ctrl_n = ctrl;
        isol_n = isol;
        ps_n = ps;
        dom_n = dom;
        on_n = on;
        cnt_n = cnt == 8'd0 ? 8'd0 : cnt - 8'd1;
        done_n = 1'b0;
        err_n = 1'b0;
        case (state)
            IDLE: if (req.req_valid && req.req_ready) begin
                if (req.req_dom > 3'd4) err_n = 1'b1;
                else if ((|(ps & req_sel)) == req.req_on) done_n = 1'b1;
                else begin
                    dom_n = req.req_dom;
                    on_n = req.req_on;
                    state_n = req.req_on ? SW_ON : ISO_SET;
                    ctrl_n = req.req_on ? ctrl | req_sel : ctrl;
                    isol_n = req.req_on ? isol | req_sel : isol;
                end
            end
            ISO_SET: begin
                isol_n = isol | sel;
                cnt_n = ISO_CNT;
                state_n = ISO_WAIT;
            end
            ISO_WAIT: if (cnt == 8'd1) begin
                ctrl_n = ctrl & ~sel;
                state_n = SW_OFF;
            end
            SW_OFF, SW_ON: begin
                cnt_n = ACK_CNT;
                state_n = ACK_WAIT;
            end
            ACK_WAIT: begin
                if (ack_hit) begin
                    ps_n = on ? ps | sel : ps & ~sel;
                    state_n = on ? DEISO_WAIT : IDLE;
                    done_n = ~on;
                    if (on) cnt_n = ISO_CNT;
                end
`ifdef LPUPF_TIMEOUT_EN
                else if (cnt == 8'd1) begin
                    isol_n = isol | sel;
                    ctrl_n = ctrl & ~sel;
                    ps_n = ps & ~sel;
                    err_n = 1'b1;
                    state_n = IDLE;
                end
`endif
            end
            DEISO_WAIT: if (cnt == 8'd1) begin
                isol_n = isol & ~sel;
                state_n = ISO_CLR;
            end
            ISO_CLR: begin
                done_n = 1'b1;
                state_n = IDLE;
            end
        endcase
    end
    // state and output registers; reset leaves every domain powered and unclamped
    always_ff @(posedge clk_upf or negedge rst_n_upf) begin
        if (!rst_n_upf) begin
            state <= IDLE;
            ctrl <= '1;
            isol <= '0;
            ps <= '1;
            cnt <= '0;
            dom <= '0;
            on <= 1'b1;
            done <= 1'b0;
            err <= 1'b0;
            live <= 1'b0;
        end else begin
            state <= state_n;
            ctrl <= ctrl_n;
            isol <= isol_n;
            ps <= ps_n;
            cnt <= cnt_n;
            dom <= dom_n;
            on <= on_n;
            done <= done_n;
            err <= err_n;
            live <= 1'b1;
        end
    end
endmodule
